// File: rtl/spike_event_logger.sv
// Spike event logger: rising-edge detection on the axon level, programmable
// refractory holdoff, free-running timestamping, and a first-word-fall-through
// timestamp FIFO drained over a valid/ready handshake. Overflow is sticky and
// dropped events are counted with saturation.
module spike_event_logger #(
  parameter int unsigned TS_W     = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned REFRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     axon,
  input  logic [REFRAC_W-1:0]      refrac_len,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Timestamp counter and edge-detect history
  logic [TS_W-1:0]     ts_q, ts_d;
  logic                axon_q;

  // Refractory holdoff counter
  logic [REFRAC_W-1:0] refr_q, refr_d;

  // FIFO storage and bookkeeping
  logic [TS_W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  // Overflow reporting
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;

  // Per-cycle event decode
  logic                spike;
  logic                accept;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drop;

  // Decode spike acceptance and FIFO push/pop/drop for this cycle
  always_comb begin
    spike      = axon & ~axon_q;
    accept     = spike & enable & (refr_q == '0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    pop        = ~fifo_empty & ev_ready;
    // A full FIFO still takes the write when the head leaves in the same cycle
    push       = accept & (~fifo_full | pop);
    drop       = accept & fifo_full & ~pop;
  end

  // Next-state for the timestamp counter and refractory counter
  always_comb begin
    ts_d   = ts_q;
    refr_d = refr_q;
    if (enable) begin
      ts_d = ts_q + TS_W'(1);
    end
    if (accept) begin
      refr_d = refrac_len;
    end else if (enable && (refr_q != '0)) begin
      refr_d = refr_q - REFRAC_W'(1);
    end
  end

  // Next-state for FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state for sticky overflow and saturating drop counter
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // A drop in the same cycle as a clear wins: the clear resets the count
    // and the new drop is counted on top of it
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (clear_ovf) begin
      drop_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= '0;
      axon_q   <= 1'b0;
      refr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      axon_q   <= axon;
      refr_q   <= refr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage write; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign ev_valid = ~fifo_empty;
  assign ev_ts    = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign ev_count = count_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: a negedge reference model feeds
// an expected-timestamp queue, plus scenario tasks with inline checks.
module tb_spike_event_logger;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        axon = 1'b0;
  logic [7:0]  refrac_len = '0;
  logic        ev_ready = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [3:0]  ev_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  // Narrow-timestamp instance for wrap checks
  logic        rst4 = 1'b0;
  logic        en4 = 1'b0;
  logic        axon4 = 1'b0;
  logic [7:0]  refrac4 = '0;
  logic        ready4 = 1'b0;
  logic        clear4 = 1'b0;
  logic        ev_valid4;
  logic [3:0]  ev_ts4;
  logic [3:0]  ev_count4;
  logic        overflow4;
  logic [7:0]  drop_cnt4;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, advanced at each negedge to the post-posedge value
  logic [15:0] m_ts = '0;
  logic        m_axq = 1'b0;
  logic [7:0]  m_refr = '0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_drop = '0;
  logic [15:0] exp_q[$];

  spike_event_logger #(.TS_W(16), .DEPTH(DEPTH), .REFRAC_W(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .axon(axon), .refrac_len(refrac_len),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_ts(ev_ts), .ev_count(ev_count),
    .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
  );

  spike_event_logger #(.TS_W(4), .DEPTH(DEPTH), .REFRAC_W(8)) u_dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .axon(axon4), .refrac_len(refrac4),
    .ev_ready(ready4), .ev_valid(ev_valid4), .ev_ts(ev_ts4), .ev_count(ev_count4),
    .overflow(overflow4), .drop_cnt(drop_cnt4), .clear_ovf(clear4)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare DUT against the model, then step the model
  always @(negedge clk) begin
    logic spike, acc, pop, full, drp;
    logic [15:0] exp_ts;
    if (!rst) begin
      exp_q.delete();
      m_ts = '0; m_axq = 1'b0; m_refr = '0; m_ovf = 1'b0; m_drop = '0;
    end
    exp_ts = (exp_q.size() != 0) ? exp_q[0] : 16'd0;
    vectors++;
    if (ev_valid !== (exp_q.size() != 0) || ev_count !== 4'(exp_q.size())) begin
      miscompares++;
      $display("FAIL sb_occupancy: got valid=%0b count=%0d want valid=%0b count=%0d",
               ev_valid, ev_count, (exp_q.size() != 0), exp_q.size());
    end
    vectors++;
    if (ev_ts !== exp_ts) begin
      miscompares++;
      $display("FAIL sb_ev_ts: got %0d want %0d", ev_ts, exp_ts);
    end
    vectors++;
    if (overflow !== m_ovf || drop_cnt !== m_drop) begin
      miscompares++;
      $display("FAIL sb_overflow: got ovf=%0b drop=%0d want ovf=%0b drop=%0d",
               overflow, drop_cnt, m_ovf, m_drop);
    end
    if (rst) begin
      spike = axon & ~m_axq;
      acc   = spike & enable & (m_refr == 0);
      pop   = (exp_q.size() != 0) & ev_ready;
      full  = (exp_q.size() == DEPTH);
      drp   = acc & full & ~pop;
      if (pop) void'(exp_q.pop_front());
      if (acc && !drp) exp_q.push_back(m_ts);
      if (drp) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (clear_ovf) m_drop = drp ? 8'd1 : 8'd0;
      else if (drp && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (acc) m_refr = refrac_len;
      else if (enable && m_refr != 0) m_refr = m_refr - 8'd1;
      m_axq = axon;
      if (enable) m_ts = m_ts + 16'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; axon = 1'b0; ev_ready = 1'b0;
    clear_ovf = 1'b0; refrac_len = '0;
    cyc(); cyc();
    rst = 1'b1; enable = 1'b1;
  endtask

  task automatic wait_ts(input logic [15:0] target);
    int n = 0;
    while (m_ts != target && n < 300) begin
      cyc();
      n++;
    end
    vectors++;
    if (m_ts != target) begin
      miscompares++;
      $display("FAIL wait_ts: got %0d want %0d", m_ts, target);
    end
  endtask

  task automatic drain();
    int n = 0;
    ev_ready = 1'b1;
    while (ev_valid === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    ev_ready = 1'b0;
    vectors++;
    if (ev_count !== 4'd0) begin
      miscompares++;
      $display("FAIL drain_empty: got %0d want 0", ev_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(); cyc();
    vectors++;
    if (ev_valid !== 1'b0 || ev_ts !== 16'd0 || ev_count !== 4'd0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%0b ts=%0d count=%0d ovf=%0b drop=%0d want all 0",
               ev_valid, ev_ts, ev_count, overflow, drop_cnt);
    end
  endtask

  task automatic test_single_spike();
    do_reset();
    wait_ts(16'd5);
    axon = 1'b1;
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pre_valid: got %0b want 0", ev_valid);
    end
    cyc();
    vectors++;
    if (ev_valid !== 1'b1 || ev_ts !== 16'd5) begin
      miscompares++;
      $display("FAIL single_first: got valid=%0b ts=%0d want valid=1 ts=5", ev_valid, ev_ts);
    end
    cyc(); cyc();
    axon = 1'b0;
    vectors++;
    if (ev_count !== 4'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 1", ev_count);
    end
    ev_ready = 1'b1;
    cyc();
    ev_ready = 1'b0;
    vectors++;
    if (ev_count !== 4'd0 || ev_valid !== 1'b0 || ev_ts !== 16'd0) begin
      miscompares++;
      $display("FAIL single_pop: got count=%0d valid=%0b ts=%0d want 0 0 0",
               ev_count, ev_valid, ev_ts);
    end
  endtask

  task automatic test_refractory();
    do_reset();
    refrac_len = 8'd4;
    wait_ts(16'd10);
    axon = 1'b1; cyc();
    axon = 1'b0; cyc();
    axon = 1'b1; cyc();
    axon = 1'b0; cyc(); cyc(); cyc();
    axon = 1'b1; cyc();
    axon = 1'b0;
    vectors++;
    if (ev_count !== 4'd2 || ev_ts !== 16'd10 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL refrac_log: got count=%0d ts=%0d drop=%0d want count=2 ts=10 drop=0",
               ev_count, ev_ts, drop_cnt);
    end
    ev_ready = 1'b1; cyc(); ev_ready = 1'b0;
    vectors++;
    if (ev_ts !== 16'd16) begin
      miscompares++;
      $display("FAIL refrac_second: got %0d want 16", ev_ts);
    end
    drain();
    refrac_len = '0;
  endtask

  task automatic test_overflow();
    logic [15:0] first_ts;
    do_reset();
    first_ts = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) first_ts = m_ts;
      axon = 1'b1; cyc();
      axon = 1'b0; cyc();
    end
    vectors++;
    if (ev_count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2 || ev_ts !== first_ts) begin
      miscompares++;
      $display("FAIL ovf_full: got count=%0d ovf=%0b drop=%0d ts=%0d want 8 1 2 %0d",
               ev_count, overflow, drop_cnt, ev_ts, first_ts);
    end
    axon = 1'b1; ev_ready = 1'b1; cyc();
    axon = 1'b0; ev_ready = 1'b0;
    vectors++;
    if (ev_count !== 4'd8 || drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL ovf_push_pop: got count=%0d drop=%0d want 8 2", ev_count, drop_cnt);
    end
    drain();
  endtask

  task automatic test_clear_ovf();
    for (int i = 0; i < 8; i++) begin
      axon = 1'b1; cyc();
      axon = 1'b0; cyc();
    end
    axon = 1'b1; clear_ovf = 1'b1; cyc();
    axon = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL clear_with_drop: got ovf=%0b drop=%0d want 1 1", overflow, drop_cnt);
    end
    cyc();
    clear_ovf = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL clear_plain: got ovf=%0b drop=%0d want 0 0", overflow, drop_cnt);
    end
    drain();
  endtask

  task automatic test_ts_wrap();
    rst4 = 1'b1; en4 = 1'b1;
    repeat (15) cyc();
    axon4 = 1'b1; cyc();
    axon4 = 1'b0;
    vectors++;
    if (ev_valid4 !== 1'b1 || ev_ts4 !== 4'd15) begin
      miscompares++;
      $display("FAIL wrap_first: got valid=%0b ts=%0d want 1 15", ev_valid4, ev_ts4);
    end
    cyc();
    axon4 = 1'b1; cyc();
    axon4 = 1'b0;
    vectors++;
    if (ev_count4 !== 4'd2) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d want 2", ev_count4);
    end
    ready4 = 1'b1; cyc();
    vectors++;
    if (ev_ts4 !== 4'd1 || ev_count4 !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_second: got ts=%0d count=%0d want 1 1", ev_ts4, ev_count4);
    end
    cyc();
    ready4 = 1'b0;
    vectors++;
    if (ev_count4 !== 4'd0 || ev_valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_drain: got count=%0d valid=%0b want 0 0", ev_count4, ev_valid4);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      axon = 1'b1; cyc();
      axon = 1'b0; cyc();
    end
    vectors++;
    if (ev_count !== 4'd5) begin
      miscompares++;
      $display("FAIL areset_fill: got %0d want 5", ev_count);
    end
    axon = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (ev_valid !== 1'b0 || ev_count !== 4'd0 || ev_ts !== 16'd0) begin
      miscompares++;
      $display("FAIL areset_immediate: got valid=%0b count=%0d ts=%0d want 0 0 0",
               ev_valid, ev_count, ev_ts);
    end
    cyc();
    rst = 1'b1;
    cyc();
    axon = 1'b0;
    vectors++;
    if (ev_valid !== 1'b1 || ev_ts !== 16'd0 || ev_count !== 4'd1) begin
      miscompares++;
      $display("FAIL areset_first_spike: got valid=%0b ts=%0d count=%0d want 1 0 1",
               ev_valid, ev_ts, ev_count);
    end
    drain();
  endtask

  initial begin
    cyc();
    test_reset();
    test_single_spike();
    test_refractory();
    test_overflow();
    test_clear_ovf();
    test_ts_wrap();
    test_async_reset();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
Downstream consumer of the neuron's axon output.
- Detects rising edges of axon and applies a programmable refractory holdoff.
- Timestamps each accepted spike with a free-running cycle counter.
- Buffers the timestamps in a small first-word-fall-through FIFO that a router or host drains through a valid/ready interface.
- Reports overflow and a count of dropped events.

Parameters:
TS_W, 16, timestamp counter and event width in bits
DEPTH, 8, FIFO entries; power of two, minimum 2
REFRAC_W, 8, refractory length field width

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  1 = run timestamp counter and accept spikes
axon  in  1  spike level from the neuron comparator
refrac_len  in  REFRAC_W  holdoff cycles after an accepted spike; 0 = none
ev_ready  in  1  consumer ready
ev_valid  out  1  FIFO non-empty; head event presented
ev_ts  out  TS_W  head event timestamp; 0 when empty
ev_count  out  log2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when a spike is dropped
drop_cnt  out  8  dropped spikes, saturating at 255
clear_ovf  in  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (rst=0, async) clears:
  - ts counter, axon_q, refractory counter, FIFO pointers: 0.
  - Outputs: ev_valid=0, ev_ts=0, ev_count=0, overflow=0, drop_cnt=0.
- Timestamp counter ts:
  - Increments every cycle while enable=1.
  - Wraps from 2^TS_W-1 to 0.
  - Holds while enable=0.
- Edge detect:
  - axon_q registers axon every cycle, regardless of enable.
  - spike = axon & ~axon_q. A level held high yields exactly one spike.
  - axon high at the first posedge after reset release counts as a spike.
- Accept condition: spike & enable & (refr==0).
  - Spikes during refractory or with enable=0 are ignored.
  - Ignored spikes are not drops.
- Refractory counter refr:
  - On accept, loads refrac_len.
  - Otherwise decrements toward 0 while enable=1; holds while enable=0.
  - refrac_len=N blocks accepts for the N cycles after the accepting edge.
  - refrac_len=0 permits back-to-back accepts, with spacing limited by edge detect (minimum 2 cycles).
- Captured timestamp is the ts value before that edge's increment.
- Latency: an accepted spike sampled at posedge k is written at posedge k. With the FIFO previously empty, ev_valid=1 and ev_ts=timestamp right after posedge k.
- Read: pop at a posedge where ev_valid & ev_ready.
  - ev_ts shows the next entry, or 0 if the FIFO becomes empty.
  - ev_ready while empty has no effect.
- Write while full:
  - Simultaneous pop: write accepted; occupancy stays DEPTH.
  - No pop: event dropped; overflow set; drop_cnt increments, saturating at 255.
- clear_ovf: clears overflow and drop_cnt.
  - Clear and drop in the same cycle: overflow=1, drop_cnt=1.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy tracks 0..DEPTH inclusive.
- enable=0 does not stall draining; FIFO contents persist.
- Reset mid-operation discards all FIFO contents immediately (async).

Test Plan:
1. Reset, enable=1, refrac_len=0; axon pulses high at ts=5 for 3 cycles. Required: exactly one event with ev_ts=5, ev_valid rising the cycle after the edge sample; ev_ready=1 pops it and ev_count returns to 0.
2. refrac_len=4; axon rising edges at ts=10, 12 and 16. Required: events 10 and 16 logged; 12 ignored with drop_cnt=0.
3. DEPTH=8, ev_ready=0, 10 accepted spikes. Required: ev_count=8, overflow=1, drop_cnt=2, FIFO holds the first 8 timestamps in order. Next spike arriving with ev_ready=1: accepted, count stays 8, no new drop.
4. Assert clear_ovf in the same cycle as a drop. Required: overflow=1, drop_cnt=1. Clear with no drop: both 0.
5. ts preloaded near wrap (TS_W=4): spikes at ts=15 and ts=1. Required: ev_ts values 15 then 1.
6. Pull rst low mid-burst with FIFO at 5 entries. Required: ev_valid=0, ev_count=0, ev_ts=0, ts=0 immediately (asynchronous, no clock edge needed). A spike on the first posedge after release is logged with ev_ts=0.
